// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one down-counting timer between two requesters.
// Loads the winner's run length, counts it down to zero, then pulses done to that requester.
module counter_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             hold,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             ptr_reg, ptr_next;
  logic             win_reg, win_next;
  logic [1:0]       gnt_reg, gnt_next;
  logic [1:0]       done_reg, done_next;
  logic             busy_reg, busy_next;
  logic [WIDTH-1:0] result_reg, result_next;

  logic             pick;
  logic [1:0]       pick_onehot;
  logic [1:0]       win_onehot;

  // On a tie the requester that was not served last wins.
  always_comb begin
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~ptr_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick == 1'(gi));
      assign win_onehot[gi]  = (win_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    win_next    = win_reg;
    gnt_next    = gnt_reg;
    done_next   = 2'b00;
    busy_next   = busy_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          state_next  = RUN;
          win_next    = pick;
          gnt_next    = pick_onehot;
          busy_next   = 1'b1;
          result_next = pick ? len1 : len0;
        end
      end

      RUN: begin
        // A dropped request cancels the run before hold or count are considered.
        if (!req[win_reg]) begin
          state_next = IDLE;
          gnt_next   = 2'b00;
          busy_next  = 1'b0;
          ptr_next   = win_reg;
        end else if (hold) begin
          result_next = result_reg;
        end else if (result_reg != '0) begin
          result_next = result_reg - WIDTH'(1);
        end else begin
          state_next = DONE;
          gnt_next   = 2'b00;
          done_next  = win_onehot;
          ptr_next   = win_reg;
        end
      end

      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        gnt_next   = 2'b00;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      ptr_reg    <= 1'b1;
      win_reg    <= 1'b0;
      gnt_reg    <= 2'b00;
      done_reg   <= 2'b00;
      busy_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      win_reg    <= win_next;
      gnt_reg    <= gnt_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      result_reg <= result_next;
    end
  end

  assign gnt    = gnt_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an owner/countdown model.
module tb_counter_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic       hold;
  logic [1:0] gnt, done;
  logic       busy;
  logic [3:0] result;

  int errors = 0;
  int checks = 0;

  counter_scheduler #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .hold(hold), .gnt(gnt), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the timer (-1 = nobody), who is being told done, last served.
  int m_owner  = -1;
  int m_doneto = -1;
  int m_last   = 1;
  int m_result = 0;
  bit m_valid  = 0;

  always @(posedge clk) begin : model
    int o, d, l, r;
    o = m_owner; d = -1; l = m_last; r = m_result;
    if (!reset) begin
      o = -1; l = 1; r = 0;
    end else if (m_doneto >= 0) begin
      d = -1;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) o = 1 - m_last;
        else              o = req[0] ? 0 : 1;
        r = (o == 0) ? int'(len0) : int'(len1);
      end
    end else if (!req[m_owner]) begin
      l = m_owner; o = -1;
    end else if (!hold) begin
      if (r > 0) r = r - 1;
      else begin l = m_owner; d = m_owner; o = -1; end
    end
    m_owner  <= o;
    m_doneto <= d;
    m_last   <= l;
    m_result <= r;
    m_valid  <= 1'b1;
  end

  logic [1:0] prev_done = 2'b00;

  always @(negedge clk) begin
    if (m_valid) begin
      check("gnt",    int'(gnt),    (m_owner < 0) ? 0 : (1 << m_owner));
      check("done",   int'(done),   (m_doneto < 0) ? 0 : (1 << m_doneto));
      check("busy",   int'(busy),   (m_owner >= 0 || m_doneto >= 0) ? 1 : 0);
      check("result", int'(result), m_result);
      check("gnt_not_both", int'(gnt == 2'b11), 0);
      check("done_gnt_excl", int'(done != 2'b00 && gnt != 2'b00), 0);
      check("done_not_back2back", int'(done != 2'b00 && prev_done != 2'b00), 0);
      prev_done = done;
    end
  end

  task automatic pulse_reset();
    reset = 1'b0; req = 2'b00; hold = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : stim
    int n, cnt, holds;
    logic [1:0] prev_g;
    logic [1:0] gseq[4];
    int rq[$];
    int exp_hold[8] = '{4, 3, 2, 2, 2, 2, 1, 0};
    logic [1:0] exp_alt[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    reset = 1'b0; req = 2'b11; len0 = 4'd0; len1 = 4'd0; hold = 1'b0;

    // Long reset with both requesting: everything stays quiet.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_gnt", int'(gnt), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_result", int'(result), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("first_tie_gnt", int'(gnt), 1);

    // Plain run of length 3 for requester 0.
    pulse_reset();
    len0 = 4'd3; req = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("run3_gnt", int'(gnt), 1);
      check("run3_result", int'(result), 3 - i);
      @(negedge clk);
    end
    check("run3_done", int'(done), 1);
    check("run3_gnt_off", int'(gnt), 0);
    check("run3_busy_done", int'(busy), 1);
    req = 2'b00;
    @(negedge clk);
    check("run3_done_off", int'(done), 0);
    check("run3_busy_off", int'(busy), 0);

    // Both held: grants alternate starting with requester 0.
    pulse_reset();
    len0 = 4'd2; len1 = 4'd1; req = 2'b11;
    n = 0; prev_g = 2'b00;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (gnt != 2'b00 && prev_g == 2'b00) begin
        gseq[n] = gnt;
        n++;
      end
      prev_g = gnt;
    end
    check("alt_count", n, 4);
    for (int i = 0; i < n; i++) check("alt_gnt", int'(gseq[i]), int'(exp_alt[i]));
    req = 2'b00;

    // Hold pauses the count at 2 for three edges.
    pulse_reset();
    len1 = 4'd4; req = 2'b10;
    @(negedge clk);
    cnt = 0; holds = 0;
    while (gnt != 2'b00 && cnt < 20) begin
      rq.push_back(int'(result));
      if (result == 4'd2 && holds < 3) begin hold = 1'b1; holds++; end
      else hold = 1'b0;
      @(negedge clk);
      cnt++;
    end
    hold = 1'b0;
    check("hold_len", rq.size(), 8);
    for (int i = 0; i < rq.size() && i < 8; i++) check("hold_seq", rq[i], exp_hold[i]);
    check("hold_done", int'(done), 2);
    req = 2'b00;

    // Abort at result 5, then pointer favours requester 1.
    pulse_reset();
    len0 = 4'd8; req = 2'b01;
    @(negedge clk);
    cnt = 0;
    while (result != 4'd5 && cnt < 20) begin @(negedge clk); cnt++; end
    check("abort_reach", int'(result), 5);
    req = 2'b00;
    @(negedge clk);
    check("abort_gnt", int'(gnt), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 5);
    req = 2'b11;
    @(negedge clk);
    check("abort_next_gnt", int'(gnt), 2);

    // Reset mid-run: no done, pointer back to its reset value.
    pulse_reset();
    len0 = 4'd9; req = 2'b01;
    @(negedge clk);
    cnt = 0;
    while (result != 4'd6 && cnt < 20) begin @(negedge clk); cnt++; end
    check("midrst_reach", int'(result), 6);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_done", int'(done), 0);
    reset = 1'b1; req = 2'b11;
    @(negedge clk);
    check("midrst_next_gnt", int'(gnt), 1);

    // Random traffic: requesters hold until their done or an occasional abort.
    pulse_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_doneto == i) req[i] = 1'b0;
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 40) == 0) req[i] = 1'b0;
      end
      len0 = 4'($urandom_range(0, 15));
      len1 = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 250) != 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
